// File: rtl/hack_rom_loader.sv
// hack_rom_loader: instruction ROM for the Hack CPU plus a byte-stream boot loader.
// Holds the CPU in reset while the ROM is filled from a length-prefixed stream
// (LEN_HI, LEN_LO, then N words as HI/LO bytes), then releases it to run from 0.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte makes the modulo-256 sum of
// all stream bytes zero; a bad sum parks the loader in an error state.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   pc / instruction  CPU fetch port (instruction is combinational, 0 unless running)
//   in_data/in_valid/in_ready  loader byte stream, valid-ready handshake
//   reload            one-cycle request to restart loading (ROM contents kept)
//   cpu_reset         CPU reset, low only while running
//   loaded_words      data words accepted in the current load
//   load_err          checksum failure (tied low without LOADER_CHECKSUM_EN)
module hack_rom_loader #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  output logic        load_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd6;
  localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
  localparam logic [2:0] S_AFTER_DATA = S_RUN;
`endif

  logic [2:0]      state_q, state_d;
  logic [7:0]      hi_q, hi_d;        // LEN_HI or DATA_HI byte awaiting its LO partner
  logic [15:0]     len_q, len_d;
  // One extra bit: once the MSB is set the ROM is full and the address stops
  // moving, so oversized loads never wrap onto low addresses.
  logic [ADDR_W:0] addr_q, addr_d;
  logic [15:0]     words_q, words_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            accept;
  logic            mem_we;
  logic            pc_in_range;
  logic [15:0]     mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    in_ready = 1'b1;
    if (state_q == S_RUN) in_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (state_q == S_ERR) in_ready = 1'b0;
`endif
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    addr_d  = addr_q;
    words_d = words_q;
    mem_we  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    if (reload) begin
      // reload wins over a coincident byte, which is dropped
      state_d = S_LEN_HI;
      addr_d  = '0;
      words_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = 8'd0;
      err_d   = 1'b0;
`endif
    end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
      csum_d = csum_q + in_data;
`endif
      case (state_q)
        S_LEN_HI: begin
          hi_d    = in_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = {hi_q, in_data};
          state_d = ({hi_q, in_data} == 16'd0) ? S_AFTER_DATA : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          mem_we  = ~addr_q[ADDR_W];
          if (!addr_q[ADDR_W]) addr_d = addr_q + {{ADDR_W{1'b0}}, 1'b1};
          words_d = words_q + 16'd1;
          state_d = (words_q + 16'd1 == len_q) ? S_AFTER_DATA : S_DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (csum_d == 8'd0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    cpu_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      hi_q        <= 8'd0;
      len_q       <= 16'd0;
      addr_q      <= '0;
      words_q     <= 16'd0;
      cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  // ROM array: deliberately not reset, contents survive reset and reload
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[ADDR_W-1:0]] <= {hi_q, in_data};
  end

  assign pc_in_range = ((32'(pc)) >> ADDR_W) == 32'd0;
  assign instruction = (state_q == S_RUN && pc_in_range) ? mem[pc[ADDR_W-1:0]] : 16'h0000;

  assign cpu_reset    = cpu_reset_q;
  assign loaded_words = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Instruction-memory stage that feeds the Hack CPU's `instruction` input from its `pc` output. It contains the instruction ROM array and a byte-stream boot loader. After reset it holds the CPU in reset, fills the ROM from a length-prefixed byte stream, then releases the CPU to execute from address 0. A `reload` pulse repeats the load without a global reset.

## Interface

Parameters:
- `ADDR_W`, default 12: ROM address width; depth = 2**ADDR_W words of 16 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  16  CPU program counter.
- `instruction`  out  16  instruction word for the CPU.
- `in_data`  in  8  loader byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte; transfer happens when `in_valid && in_ready` at a rising edge.
- `reload`  in  1  single-cycle request to restart loading.
- `cpu_reset`  out  1  drives the CPU `reset` input.
- `loaded_words`  out  16  count of data words accepted in the current load.
- `load_err`  out  1  checksum failure (only with `LOADER_CHECKSUM_EN`).

## Operation

- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words as HI byte then LO byte. With `LOADER_CHECKSUM_EN`, one checksum byte follows.
- States:
  - S_LEN_HI → S_LEN_LO → S_DATA_HI ↔ S_DATA_LO.
  - After the last word, go to S_CSUM if `LOADER_CHECKSUM_EN` is defined, otherwise S_RUN.
  - S_CSUM goes to S_RUN on a match and S_ERR on a mismatch.
- Each state advances only on an accepted byte.
- N = 0: after LEN_LO, go directly to S_CSUM, or to S_RUN without the macro.
- Word write: on the S_DATA_LO accept, `mem[addr] <= {hi_byte, in_data}`, then `addr` and `loaded_words` increment.
  - `addr` starts at 0 for each load.
  - When `addr >= 2**ADDR_W`, the word is consumed and counted but not written. There is no wrap-around.
- `in_ready` = 1 in S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO and S_CSUM; 0 in S_RUN and S_ERR.
- `cpu_reset` = 1 in every state except S_RUN.
- `instruction` is combinational:
  - `mem[pc[ADDR_W-1:0]]` when state is S_RUN and `pc < 2**ADDR_W`.
  - Otherwise 16'h0000.
- `reload` in any state: go to S_LEN_HI next edge and clear `addr`, `loaded_words`, checksum accumulator and `load_err`.
  - If `reload` coincides with a byte accept, `reload` wins and the byte is discarded.
- ROM contents are not cleared by `reset` or `reload`. Memory is uninitialised after power-up.

## Timing

- Reset values:
  - state S_LEN_HI, `cpu_reset` = 1, `in_ready` = 1.
  - `loaded_words` = 0, `load_err` = 0, `instruction` = 0.
- `reset` asserted mid-load aborts the load immediately (asynchronous); the partial ROM contents remain.
- A write is visible on `instruction` from the edge that accepts the LO byte, once the state is S_RUN.
- Release latency: the edge that accepts the final byte sets S_RUN. `cpu_reset` falls on that edge (it is registered from state), so the CPU's first fetch from pc=0 occurs at the next edge.
- `reload` in S_RUN: `cpu_reset` rises on the next edge; `instruction` reads 0 from that edge.
- Maximum throughput is one byte per cycle. Bubbles on `in_valid` are allowed in any loading state.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit accumulator sums every accepted byte, including the length bytes and the checksum byte, modulo 256.
  - In S_CSUM, a total of 0 goes to S_RUN.
  - Any other total goes to S_ERR: `load_err` = 1, `cpu_reset` held at 1, `in_ready` = 0.
  - S_ERR exits only via `reset` or `reload`.
- `LOADER_CHECKSUM_EN` undefined:
  - There is no S_CSUM or S_ERR state.
  - `load_err` is tied to 0, and the last data word goes directly to S_RUN.

## Test plan

- Reset, then stream 00 02 EC 10 00 07 (no checksum build) with a byte every cycle:
  - `cpu_reset` falls on the 6th accept edge.
  - `loaded_words` = 2.
  - pc=0 gives 16'hEC10; pc=1 gives 16'h0007; pc=5 gives `mem[5]`.
- N=0 stream 00 00: S_RUN after 2 bytes, `cpu_reset` = 0, `loaded_words` = 0.
- Checksum build, stream 00 01 12 34 B9:
  - The bytes sum to 0x100, so the load passes and `load_err` = 0.
  - Repeat with a last byte of B8: `load_err` = 1, `cpu_reset` stays 1, `in_ready` = 0.
  - Then a `reload` pulse: `load_err` = 0 and `in_ready` = 1 next cycle.
- ADDR_W=2, N=5 with words 0001..0005:
  - `loaded_words` = 5.
  - `mem[0..3]` = 0001..0004; word 0005 is discarded.
  - pc=4 gives 0.
- `in_valid` toggling every other cycle over a 4-word load gives identical ROM contents. `reload` asserted on the same edge as LO byte 3 drops that byte: the state is S_LEN_HI next cycle and `loaded_words` = 0.
- `reset` asserted during S_DATA_LO: `cpu_reset` = 1 and `in_ready` = 1 immediately (asynchronous), and the words already written are still readable after a subsequent load of N=0.
